// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: raster read scan, window-valid tracking,
// and a result stream (valid/coords/syncs) aligned to the Sobel stage latency.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 6,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned COORD_W  = 9,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               shift_en,
  output logic               win_valid,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               hsync,
  output logic               vsync
);

  localparam int unsigned NPIX       = IMG_W * IMG_H;
  localparam int unsigned XW         = $clog2(IMG_W);
  localparam int unsigned YW         = $clog2(IMG_H);
  localparam int unsigned DRAIN_LAST = PIPE_LAT + 1;
  localparam int unsigned DW         = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [DW-1:0]       r_drain_cnt, w_drain_cnt_nx;
  logic [ADDR_W-1:0]   w_rd_addr_nx;
  logic                w_busy_nx, w_done_nx, w_rd_en_nx;

  logic [XW-1:0]       r_px;
  logic [YW-1:0]       r_py;
  logic                w_interior;
  logic                r_win_hs, r_win_vs;
  logic [COORD_W-1:0]  r_win_x, r_win_y;

  logic [PIPE_LAT-1:0] r_dv, r_dhs, r_dvs;
  logic [COORD_W-1:0]  r_dx [PIPE_LAT];
  logic [COORD_W-1:0]  r_dy [PIPE_LAT];

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    w_state_nx     = r_state;
    w_rd_addr_nx   = '0;
    w_drain_cnt_nx = '0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nx = S_READ;
      S_READ: begin
        if (rd_addr == ADDR_W'(NPIX - 1)) w_state_nx = S_DRAIN;
        else                              w_rd_addr_nx = rd_addr + ADDR_W'(1);
      end
      S_DRAIN: begin
        if (r_drain_cnt == DW'(DRAIN_LAST)) w_state_nx = S_DONE;
        else                                w_drain_cnt_nx = r_drain_cnt + DW'(1);
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx  = (w_state_nx != S_IDLE);
    w_rd_en_nx = (w_state_nx == S_READ);
    w_done_nx  = (w_state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_drain_cnt <= w_drain_cnt_nx;
      rd_addr     <= w_rd_addr_nx;
      busy        <= w_busy_nx;
      done        <= w_done_nx;
      rd_en       <= w_rd_en_nx;
    end
  end

  // (r_px, r_py) is the pixel just shifted in; the window centre is one up and one left.
  assign w_interior = (r_px >= XW'(2)) && (r_py >= YW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_en  <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      win_valid <= 1'b0;
      r_win_hs  <= 1'b0;
      r_win_vs  <= 1'b0;
      r_win_x   <= '0;
      r_win_y   <= '0;
    end else begin
      shift_en  <= rd_en;
      win_valid <= shift_en && w_interior;
      r_win_hs  <= shift_en && w_interior && (r_px == XW'(IMG_W - 1));
      r_win_vs  <= shift_en && (r_px == XW'(2)) && (r_py == YW'(2));
      if (shift_en && w_interior) begin
        r_win_x <= COORD_W'(r_px - XW'(1));
        r_win_y <= COORD_W'(r_py - YW'(1));
      end
      if (r_state == S_IDLE) begin
        r_px <= '0;
        r_py <= '0;
      end else if (shift_en) begin
        if (r_px == XW'(IMG_W - 1)) begin
          r_px <= '0;
          r_py <= (r_py == YW'(IMG_H - 1)) ? '0 : r_py + YW'(1);
        end else begin
          r_px <= r_px + XW'(1);
        end
      end
    end
  end

  // Latency-matching delay line; coordinates only advance with valid data so outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv  <= '0;
      r_dhs <= '0;
      r_dvs <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_dx[i] <= '0;
        r_dy[i] <= '0;
      end
    end else begin
      r_dv[0]  <= win_valid;
      r_dhs[0] <= r_win_hs;
      r_dvs[0] <= r_win_vs;
      if (win_valid) begin
        r_dx[0] <= r_win_x;
        r_dy[0] <= r_win_y;
      end
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dv[i]  <= r_dv[i-1];
        r_dhs[i] <= r_dhs[i-1];
        r_dvs[i] <= r_dvs[i-1];
        if (r_dv[i-1]) begin
          r_dx[i] <= r_dx[i-1];
          r_dy[i] <= r_dy[i-1];
        end
      end
    end
  end

  assign out_valid = r_dv[PIPE_LAT-1];
  assign hsync     = r_dhs[PIPE_LAT-1];
  assign vsync     = r_dvs[PIPE_LAT-1];
  assign out_x     = r_dx[PIPE_LAT-1];
  assign out_y     = r_dy[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: per-cycle comparison against a
// cycle-offset model of the frame timeline, with directed and random stimulus.
module tb_sobel_frame_ctrl;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int AW     = 16;
  localparam int CW     = 9;
  localparam int P      = 2;
  localparam int N      = W * H;
  localparam int DONE_D = N + 2 + P;
  localparam int NRES   = (W - 2) * (H - 2);

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en, shift_en, win_valid, out_valid, hsync, vsync;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] out_x, out_y;

  int            cyc;
  int            t0;
  int            tests;
  int            fails;
  int            act_cnt;
  int            hold_x, hold_y;

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW), .PIPE_LAT(P)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .shift_en(shift_en), .win_valid(win_valid), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Window for read k: centre c = k-(W+1); interior test by plain div/mod.
  task automatic win_of(input int k, output logic v, output int x, output int y);
    int c;
    v = 1'b0; x = 0; y = 0;
    if (k >= 0 && k < N) begin
      c = k - (W + 1);
      if (c >= 0) begin
        x = c % W;
        y = c / W;
        v = (x >= 1) && (x <= W - 2) && (y >= 1) && (y <= H - 2);
      end
    end
  endtask

  function automatic logic model_idle();
    return (t0 < 0) || (cyc - t0 > DONE_D);
  endfunction

  // Drive inputs for one cycle, advance past the edge, update model, compare.
  task automatic step(input logic st, input logic rs);
    logic idle, wv, ov;
    int   d, wx, wy, ox, oy;
    start = st;
    rst   = rs;
    idle  = model_idle();
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      t0 = -1; hold_x = 0; hold_y = 0; act_cnt = 0;
    end else if (idle && st) begin
      t0 = cyc;
    end
    d = (t0 < 0) ? -1000 : cyc - t0;
    win_of(d - 2, wv, wx, wy);
    win_of(d - 2 - P, ov, ox, oy);
    if (ov) begin hold_x = ox; hold_y = oy; end
    if (out_valid === 1'b1) act_cnt++;
    chk("busy",      32'(busy),      32'(d >= 0 && d <= DONE_D));
    chk("done",      32'(done),      32'(d == DONE_D));
    chk("rd_en",     32'(rd_en),     32'(d >= 0 && d < N));
    if (d >= 0 && d < N) chk("rd_addr", 32'(rd_addr), 32'(d));
    chk("shift_en",  32'(shift_en),  32'(d >= 1 && d <= N));
    chk("win_valid", 32'(win_valid), 32'(wv));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_x",     32'(out_x),     32'(hold_x));
    chk("out_y",     32'(out_y),     32'(hold_y));
    chk("hsync",     32'(hsync),     32'(ov && ox == W - 2));
    chk("vsync",     32'(vsync),     32'(ov && ox == 1 && oy == 1));
    if (d == DONE_D) begin
      chk("result_count", 32'(act_cnt), 32'(NRES));
      act_cnt = 0;
    end
  endtask

  // Run to the end of the current frame; mode 1 adds start pulses at t0+10 and at the done cycle.
  task automatic run_frame(input int mode);
    for (int i = 0; i < DONE_D + 4 && !model_idle(); i++) begin
      step((mode == 1) && (cyc - t0 == 10 || cyc - t0 == DONE_D), 1'b0);
    end
  endtask

  initial begin
    cyc = 0; t0 = -1; tests = 0; fails = 0; act_cnt = 0; hold_x = 0; hold_y = 0;
    start = 1'b0;
    rst   = 1'b1;

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Plain frame, then a frame with starts during READ and during DONE.
    step(1'b1, 1'b0);
    run_frame(0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_frame(1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Reset asserted during cycle t0+30 aborts the frame; a later frame runs clean.
    step(1'b1, 1'b0);
    while (cyc - t0 < 30) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_frame(0);

    // Start held high: back-to-back frames separated by one idle cycle.
    for (int i = 0; i < 3 * (DONE_D + 2) + 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_frame(0);
    step(1'b0, 1'b0);

    // Random gaps, random stray starts and rare random resets.
    for (int f = 0; f < 6; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < DONE_D + 3; i++)
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
    end
    for (int i = 0; i < DONE_D + 4; i++) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
